// File: rtl/pll_reconfig_if.sv
// Request/response and PLL-side signal bundle for pll_reconfig_seq.
// master = command decode plus PLL model side, slave = the sequencer.
interface pll_reconfig_if #(
  parameter int CFG_WIDTH = 16
);
  logic                 req;
  logic [CFG_WIDTH-1:0] req_data;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 err_sticky;
  logic [2:0]           retry_cnt;
  logic [CFG_WIDTH-1:0] pll_data;
  logic                 pll_trigger;
  logic                 pll_reset;
  logic                 pll_stable;
  logic                 pll_locked;

  modport master (
    output req, req_data, pll_stable, pll_locked,
    input  busy, done, error, err_sticky, retry_cnt, pll_data, pll_trigger, pll_reset
  );

  modport slave (
    input  req, req_data, pll_stable, pll_locked,
    output busy, done, error, err_sticky, retry_cnt, pll_data, pll_trigger, pll_reset
  );
endinterface

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: load word, trigger, wait stable/lock, settle, retry on timeout.
// Optional feature macro PLL_SEQ_SKIP_SAME_EN: skip the sequence when re-requesting the locked word.
module pll_reconfig_seq #(
  parameter int CFG_WIDTH     = 16,
  parameter int TIMEOUT_WIDTH = 20,
  parameter int SETTLE_CYCLES = 256,
  parameter int RST_CYCLES    = 4,
  parameter int MAX_RETRIES   = 3
) (
  input logic           clock,
  input logic           reset_n,
  pll_reconfig_if.slave bus
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX   = {TIMEOUT_WIDTH{1'b1}};
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_ONE   = TIMEOUT_WIDTH'(1);
  localparam logic [CNT_W-1:0]         CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]         SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [RST_W-1:0]         RST_ONE     = RST_W'(1);
  localparam logic [RST_W-1:0]         RST_LAST    = RST_W'(RST_CYCLES);
  localparam logic [2:0]               RETRY_LIMIT = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TRIG     = 3'd1,
    ST_WAIT_STB = 3'd2,
    ST_WAIT_LCK = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_RETRY    = 3'd5,
    ST_DONE     = 3'd6,
    ST_FAIL     = 3'd7
  } state_t;

  state_t                 state_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   error_r;
  logic                   err_sticky_r;
  logic [2:0]             retry_cnt_r;
  logic [CFG_WIDTH-1:0]   pll_data_r;
  logic                   pll_trigger_r;
  logic                   pll_reset_r;
  logic [TIMEOUT_WIDTH-1:0] timer_r;
  logic [CNT_W-1:0]       settle_cnt_r;
  logic [RST_W-1:0]       rst_cnt_r;

`ifdef PLL_SEQ_SKIP_SAME_EN
  logic                   last_valid_r;
  logic [CFG_WIDTH-1:0]   last_data_r;
  logic                   skip_r;
  logic                   skip_ok_s;

  assign skip_ok_s = last_valid_r && (last_data_r == bus.req_data) && bus.pll_locked;
`endif

  function automatic logic [TIMEOUT_WIDTH-1:0] sat_inc(input logic [TIMEOUT_WIDTH-1:0] v);
    if (v == TIMER_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + TIMER_ONE;
    end
  endfunction

  // Sequencer FSM; every output is a register written here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      err_sticky_r  <= 1'b0;
      retry_cnt_r   <= 3'd0;
      pll_data_r    <= {CFG_WIDTH{1'b0}};
      pll_trigger_r <= 1'b0;
      pll_reset_r   <= 1'b0;
      timer_r       <= {TIMEOUT_WIDTH{1'b0}};
      settle_cnt_r  <= {CNT_W{1'b0}};
      rst_cnt_r     <= {RST_W{1'b0}};
`ifdef PLL_SEQ_SKIP_SAME_EN
      last_valid_r  <= 1'b0;
      last_data_r   <= {CFG_WIDTH{1'b0}};
      skip_r        <= 1'b0;
`endif
    end else begin
      done_r        <= 1'b0;
      error_r       <= 1'b0;
      pll_trigger_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req) begin
            pll_data_r   <= bus.req_data;
            retry_cnt_r  <= 3'd0;
            err_sticky_r <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= ST_TRIG;
`ifdef PLL_SEQ_SKIP_SAME_EN
            skip_r        <= skip_ok_s;
            pll_trigger_r <= ~skip_ok_s;
`else
            pll_trigger_r <= 1'b1;
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_TRIG: begin
          timer_r      <= {TIMEOUT_WIDTH{1'b0}};
          settle_cnt_r <= {CNT_W{1'b0}};
          rst_cnt_r    <= {RST_W{1'b0}};
`ifdef PLL_SEQ_SKIP_SAME_EN
          if (skip_r) begin
            skip_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_WAIT_STB;
          end
`else
          state_r <= ST_WAIT_STB;
`endif
        end
        ST_WAIT_STB: begin
          if (bus.pll_stable) begin
            timer_r <= {TIMEOUT_WIDTH{1'b0}};
            state_r <= ST_WAIT_LCK;
          end else if (timer_r == TIMER_MAX) begin
            state_r <= ST_RETRY;
          end else begin
            timer_r <= sat_inc(timer_r);
          end
        end
        ST_WAIT_LCK: begin
          if (bus.pll_locked) begin
            settle_cnt_r <= CNT_ONE;
            timer_r      <= sat_inc(timer_r);
            state_r      <= ST_SETTLE;
          end else if (timer_r == TIMER_MAX) begin
            state_r <= ST_RETRY;
          end else begin
            timer_r <= sat_inc(timer_r);
          end
        end
        ST_SETTLE: begin
          // Timer is not cleared on lock: a lock that keeps dropping still ends in a retry.
          if (settle_cnt_r == SETTLE_LAST) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (timer_r == TIMER_MAX) begin
            state_r <= ST_RETRY;
          end else if (bus.pll_locked) begin
            timer_r      <= sat_inc(timer_r);
            settle_cnt_r <= settle_cnt_r + CNT_ONE;
          end else begin
            timer_r      <= sat_inc(timer_r);
            settle_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_RETRY: begin
          if (retry_cnt_r == RETRY_LIMIT) begin
            error_r      <= 1'b1;
            err_sticky_r <= 1'b1;
            state_r      <= ST_FAIL;
`ifdef PLL_SEQ_SKIP_SAME_EN
            last_valid_r <= 1'b0;
`endif
          end else if (rst_cnt_r == RST_LAST) begin
            pll_reset_r   <= 1'b0;
            rst_cnt_r     <= {RST_W{1'b0}};
            retry_cnt_r   <= retry_cnt_r + 3'd1;
            pll_trigger_r <= 1'b1;
            state_r       <= ST_TRIG;
          end else begin
            pll_reset_r <= 1'b1;
            rst_cnt_r   <= rst_cnt_r + RST_ONE;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
`ifdef PLL_SEQ_SKIP_SAME_EN
          last_valid_r <= 1'b1;
          last_data_r  <= pll_data_r;
`endif
        end
        ST_FAIL: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r      <= 1'b0;
          pll_reset_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.error       = error_r;
  assign bus.err_sticky  = err_sticky_r;
  assign bus.retry_cnt   = retry_cnt_r;
  assign bus.pll_data    = pll_data_r;
  assign bus.pll_trigger = pll_trigger_r;
  assign bus.pll_reset   = pll_reset_r;
endmodule
